// File: rtl/sp_ram_pkg.sv
// Shared constants and types for the parametrised single-port RAM.
// Holds read/write mode encodings and the clear-sequencer state type.
package sp_ram_pkg;

    localparam int RD_BYPASS  = 0;
    localparam int RD_PIPE    = 1;

    localparam int WR_NORMAL  = 0;
    localparam int WR_THROUGH = 1;
    localparam int WR_RBW     = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_t;

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/sp_ram_clear_fsm.sv
// Post-reset memory-clear sequencer: walks every address once, writing zero,
// then parks in RUN until the next reset. Only built with SP_RAM_CLEAR_EN.
module sp_ram_clear_fsm
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_we        = 1'b0;
        case (r_state)
            CLEAR: begin
                w_we       = 1'b1;
                w_addr_nxt = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Busy also covers the reset cycles themselves, before the state register settles.
    assign busy     = reset || (r_state == CLEAR);
    assign clr_we   = w_we && !reset;
    assign clr_addr = r_addr;

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, three write modes,
// optional output pipeline and optional post-reset clear (macro SP_RAM_CLEAR_EN).
module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  oce,
    input  logic                  wre,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     ad,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  busy
);

    localparam int NB    = byte_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
        $error("sp_ram_param: DATA_W must be a non-zero multiple of 8");
    end
    if (READ_MODE != RD_BYPASS && READ_MODE != RD_PIPE) begin : g_bad_rmode
        $error("sp_ram_param: READ_MODE must be 0 or 1");
    end
    if (WRITE_MODE != WR_NORMAL && WRITE_MODE != WR_THROUGH && WRITE_MODE != WR_RBW) begin : g_bad_wmode
        $error("sp_ram_param: WRITE_MODE must be 0, 1 or 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_stage1;
    logic [DATA_W-1:0] r_stage2;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_wdata;
    logic [NB-1:0]     w_wbe;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clr_we;
    logic              w_busy;
    logic              w_user_acc;

`ifdef SP_RAM_CLEAR_EN
    sp_ram_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .reset    (reset),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );
`else
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    assign w_user_acc = ce && !w_busy;
    assign w_old      = r_mem[ad];

    always_comb begin
        w_merged = w_old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                w_merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // The sequencer owns the write port while clearing; user writes are dropped then.
    always_comb begin
        w_waddr = ad;
        w_wdata = din;
        w_wbe   = '0;
        if (w_clr_we) begin
            w_waddr = w_clr_addr;
            w_wdata = '0;
            w_wbe   = '1;
        end else if (w_user_acc && wre) begin
            w_wbe   = be;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (w_wbe[i]) begin
                r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_busy) begin
            r_stage1 <= '0;
        end else if (ce) begin
            if (!wre) begin
                r_stage1 <= w_old;
            end else if (WRITE_MODE == WR_THROUGH) begin
                r_stage1 <= w_merged;
            end else if (WRITE_MODE == WR_RBW) begin
                r_stage1 <= w_old;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_busy) begin
            r_stage2 <= '0;
        end else if (oce) begin
            r_stage2 <= r_stage1;
        end
    end

    always_comb begin
        dout = (READ_MODE == RD_PIPE) ? r_stage2 : r_stage1;
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_sp_ram_param.sv
// Self-checking bench for sp_ram_param: five configurations share one stimulus
// stream and are compared every cycle against a word-level memory model.
module tb_sp_ram_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ce;
    logic        oce;
    logic        wre;
    logic [3:0]  be;
    logic [7:0]  ad;
    logic [31:0] din;

    logic [7:0]  dout0;
    logic [31:0] dout1, dout2, dout3, dout4;
    logic        busy0, busy1, busy2, busy3, busy4;

    sp_ram_param u0 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be[0:0]),
        .ad(ad), .din(din[7:0]), .dout(dout0), .busy(busy0)
    );
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
        .ad(ad[3:0]), .din(din), .dout(dout1), .busy(busy1)
    );
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(1)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
        .ad(ad[3:0]), .din(din), .dout(dout2), .busy(busy2)
    );
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(2)) u3 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
        .ad(ad[3:0]), .din(din), .dout(dout3), .busy(busy3)
    );
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .READ_MODE(1), .WRITE_MODE(0)) u4 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
        .ad(ad[3:0]), .din(din), .dout(dout4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents with per-word "known" flags, plus the
    // word each configuration should present on dout.
    logic [7:0]  m8  [256];
    bit          m8k [256];
    logic [31:0] m32 [16];
    bit          m32k[16];
    logic [7:0]  e0;
    logic [31:0] e1, e2, e3, e4;
    bit          k0, k1, k2, k3, k4;
    int          bc0 = 0;
    int          bc32 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] old, merged, p4;
        bit          ok, mk, pk4;
        int          a;
        if (reset) begin
            e0 = '0; e1 = '0; e2 = '0; e3 = '0; e4 = '0;
            k0 = 1; k1 = 1; k2 = 1; k3 = 1; k4 = 1;
`ifdef SP_RAM_CLEAR_EN
            bc0  = 256;
            bc32 = 16;
            for (int i = 0; i < 256; i++) begin m8[i] = '0; m8k[i] = 1; end
            for (int i = 0; i < 16; i++) begin m32[i] = '0; m32k[i] = 1; end
`endif
        end else begin
            if (bc0 > 0) begin
                bc0--;
                e0 = '0; k0 = 1;
            end else if (ce) begin
                a = int'(ad);
                if (!wre) begin
                    e0 = m8[a]; k0 = m8k[a];
                end else if (be[0]) begin
                    m8[a] = din[7:0]; m8k[a] = 1;
                end
            end

            p4 = e1; pk4 = k1;
            if (bc32 > 0) begin
                bc32--;
                e1 = '0; e2 = '0; e3 = '0; e4 = '0;
                k1 = 1; k2 = 1; k3 = 1; k4 = 1;
            end else begin
                if (ce) begin
                    a   = int'(ad[3:0]);
                    old = m32[a];
                    ok  = m32k[a];
                    merged = old;
                    for (int i = 0; i < 4; i++)
                        if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
                    mk = ok || (be == 4'hF);
                    if (!wre) begin
                        e1 = old; e2 = old; e3 = old;
                        k1 = ok;  k2 = ok;  k3 = ok;
                    end else begin
                        e2 = merged; k2 = mk;
                        e3 = old;    k3 = ok;
                        m32[a] = merged; m32k[a] = mk;
                    end
                end
                if (oce) begin
                    e4 = p4; k4 = pk4;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy0", 32'(busy0), 32'(bc0 > 0));
        chk("busy1", 32'(busy1), 32'(bc32 > 0));
        chk("busy4", 32'(busy4), 32'(bc32 > 0));
        if (k0) chk("dout0", 32'(dout0), 32'(e0));
        if (k1) chk("dout1", dout1, e1);
        if (k2) chk("dout2", dout2, e2);
        if (k3) chk("dout3", dout3, e3);
        if (k4) chk("dout4", dout4, e4);
    endtask

    typedef struct {
        bit          ce;
        bit          wre;
        logic [3:0]  be;
        logic [7:0]  ad;
        logic [31:0] din;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] x3;
    } tv_t;

    tv_t tv [15];
    int  n;

    initial begin
        k0 = 0; k1 = 0; k2 = 0; k3 = 0; k4 = 0;
        e0 = '0; e1 = '0; e2 = '0; e3 = '0; e4 = '0;
        for (int i = 0; i < 256; i++) begin m8[i] = '0; m8k[i] = 0; end
        for (int i = 0; i < 16; i++) begin m32[i] = '0; m32k[i] = 0; end

        tv[0]  = '{1, 0, 4'h0, 8'h05, 32'h0,        32'hF5F5F5F5, 32'hF5F5F5F5, 32'hF5F5F5F5};
        tv[1]  = '{1, 1, 4'hF, 8'h05, 32'h11223344, 32'hF5F5F5F5, 32'h11223344, 32'hF5F5F5F5};
        tv[2]  = '{1, 1, 4'h5, 8'h05, 32'hAABBCCDD, 32'hF5F5F5F5, 32'h11BB33DD, 32'h11223344};
        tv[3]  = '{1, 0, 4'h0, 8'h05, 32'h0,        32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
        tv[4]  = '{1, 1, 4'hF, 8'h09, 32'h0000005A, 32'h11BB33DD, 32'h0000005A, 32'hF9F9F9F9};
        tv[5]  = '{1, 1, 4'hF, 8'h09, 32'h000000C3, 32'h11BB33DD, 32'h000000C3, 32'h0000005A};
        tv[6]  = '{1, 0, 4'h0, 8'h09, 32'h0,        32'h000000C3, 32'h000000C3, 32'h000000C3};
        tv[7]  = '{1, 1, 4'hF, 8'h03, 32'h00000077, 32'h000000C3, 32'h00000077, 32'hF3F3F3F3};
        tv[8]  = '{1, 1, 4'h0, 8'h07, 32'h12345678, 32'h000000C3, 32'hF7F7F7F7, 32'hF7F7F7F7};
        tv[9]  = '{1, 0, 4'h0, 8'h07, 32'h0,        32'hF7F7F7F7, 32'hF7F7F7F7, 32'hF7F7F7F7};
        tv[10] = '{1, 1, 4'h8, 8'h07, 32'h12345678, 32'hF7F7F7F7, 32'h12F7F7F7, 32'hF7F7F7F7};
        tv[11] = '{1, 0, 4'h0, 8'h07, 32'h0,        32'h12F7F7F7, 32'h12F7F7F7, 32'h12F7F7F7};
        tv[12] = '{0, 0, 4'h0, 8'h05, 32'h0,        32'h12F7F7F7, 32'h12F7F7F7, 32'h12F7F7F7};
        tv[13] = '{0, 1, 4'hF, 8'h07, 32'hFFFFFFFF, 32'h12F7F7F7, 32'h12F7F7F7, 32'h12F7F7F7};
        tv[14] = '{1, 0, 4'h0, 8'h07, 32'h0,        32'h12F7F7F7, 32'h12F7F7F7, 32'h12F7F7F7};

        reset = 1'b1; ce = 1'b0; oce = 1'b0; wre = 1'b0; be = '0; ad = '0; din = '0;
        repeat (3) step();
        chk("rst_dout0", 32'(dout0), 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dout4", dout4, 32'h0);
`ifdef SP_RAM_CLEAR_EN
        chk("rst_busy0", 32'(busy0), 32'h1);
`else
        chk("rst_busy0", 32'(busy0), 32'h0);
`endif
        reset = 1'b0;

`ifdef SP_RAM_CLEAR_EN
        n = 0;
        while (busy0 === 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("clear_len", 32'(n), 32'd256);
        ce = 1'b1; wre = 1'b0;
        ad = 8'h00; step(); chk("clr_rd00", 32'(dout0), 32'h0);
        ad = 8'h7F; step(); chk("clr_rd7F", 32'(dout0), 32'h0);
        ad = 8'hFF; step(); chk("clr_rdFF", 32'(dout0), 32'h0);
`else
        step();
        chk("noclr_busy", 32'(busy0), 32'h0);
`endif

        // Fill every word; the 32-bit instances alias onto ad[3:0].
        ce = 1'b1; wre = 1'b1; be = 4'hF; oce = 1'b1;
        for (int a = 0; a < 256; a++) begin
            ad  = 8'(a);
            din = {4{8'(a)}};
            step();
        end

        for (int i = 0; i < 15; i++) begin
            ce = tv[i].ce; wre = tv[i].wre; be = tv[i].be; ad = tv[i].ad; din = tv[i].din;
            step();
            chk($sformatf("tv%0d_wm0", i), dout1, tv[i].x1);
            chk($sformatf("tv%0d_wthru", i), dout2, tv[i].x2);
            chk($sformatf("tv%0d_rbw", i), dout3, tv[i].x3);
        end

        // Output-register gating: oce low holds stage 2 until the edge after oce rises.
        oce = 1'b1; ce = 1'b1; wre = 1'b0; ad = 8'h05; step();
        ce = 1'b0; step();
        chk("pipe_pre", dout4, 32'h11BB33DD);
        oce = 1'b0; ce = 1'b1; ad = 8'h03; step();
        chk("pipe_s1", dout1, 32'h00000077);
        chk("pipe_hold0", dout4, 32'h11BB33DD);
        ce = 1'b0; step();
        chk("pipe_hold1", dout4, 32'h11BB33DD);
        step();
        chk("pipe_hold2", dout4, 32'h11BB33DD);
        oce = 1'b1; step();
        chk("pipe_out", dout4, 32'h00000077);

`ifdef SP_RAM_CLEAR_EN
        reset = 1'b1; ce = 1'b0; step();
        reset = 1'b0;
        repeat (100) step();
        reset = 1'b1; step();
        reset = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 400) begin
            ce = 1'b1; wre = 1'b1; be = 4'hF;
            ad = 8'h10 + 8'(n % 4); din = $urandom;
            step();
            n++;
        end
        chk("restart_len", 32'(n), 32'd256);
        ce = 1'b1; wre = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ad = 8'h10 + 8'(i);
            step();
            chk($sformatf("busy_wr_rd%0d", i), 32'(dout0), 32'h0);
        end
`else
        ce = 1'b1; wre = 1'b1; be = 4'hF; ad = 8'h01; din = 32'h00000042; step();
        ce = 1'b0; wre = 1'b0; reset = 1'b1; step();
        chk("rst_keep_busy", 32'(busy0), 32'h0);
        chk("rst_keep_dout", 32'(dout0), 32'h0);
        reset = 1'b0; ce = 1'b1; ad = 8'h01; step();
        chk("rst_keep_mem", 32'(dout0), 32'h42);
`endif

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            ce    = ($urandom_range(0, 3) != 0);
            wre   = $urandom_range(0, 1) == 1;
            be    = 4'($urandom);
            ad    = 8'($urandom);
            din   = $urandom;
            oce   = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
